// File: rtl/job_dispatcher.sv
// rtl/job_dispatcher.sv - operand FIFO feeding one job at a time to the iterative controller
module job_dispatcher #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              start,
   output logic [DATA_W-1:0] operand,
   input  logic              done,
   output logic              busy,
   output logic [CNT_W-1:0]  level,
   output logic [7:0]        jobs_done
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic              push, pop, job_end;

   // No full-bypass: a pop in the same cycle does not make room for a push.
   assign in_ready = (level != CNT_W'(DEPTH));
   assign push     = in_valid && in_ready;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      job_end   = 1'b0;
      case (state)
         IDLE: begin
            if (level != '0) begin
               pop       = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: state_nxt = WAIT;
         WAIT: begin
            if (done) begin
               job_end = 1'b1;
               if (level != '0) begin
                  pop       = 1'b1;
                  state_nxt = LAUNCH;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level     <= '0;
         start     <= 1'b0;
         busy      <= 1'b0;
         operand   <= '0;
         jobs_done <= '0;
      end else begin
         state <= state_nxt;
         start <= (state_nxt == LAUNCH);
         busy  <= (state_nxt != IDLE);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            operand <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (job_end) jobs_done <= jobs_done + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: tb/tb_job_dispatcher.sv
// tb/tb_job_dispatcher.sv - randomized and directed checks of job_dispatcher against a queue model
module tb_job_dispatcher;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              start;
   logic [DATA_W-1:0] operand;
   logic              done = 1'b0;
   logic              busy;
   logic [CNT_W-1:0]  level;
   logic [7:0]        jobs_done;

   job_dispatcher #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .start(start), .operand(operand), .done(done),
      .busy(busy), .level(level), .jobs_done(jobs_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a queue of waiting words, plus whether a job is out and whether it was just launched.
   logic [DATA_W-1:0] mq[$];
   bit                m_busy  = 0;
   bit                m_start = 0;
   logic [DATA_W-1:0] m_op    = '0;
   logic [7:0]        m_cnt   = '0;
   bit                m_acc, m_free;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_busy = 0; m_start = 0; m_op = '0; m_cnt = '0;
      end else begin
         m_acc  = in_valid && (mq.size() < DEPTH);
         m_free = !m_busy;
         if (m_busy && !m_start && done) begin
            m_cnt  = m_cnt + 8'd1;
            m_free = 1;
         end
         if (m_free && mq.size() > 0) begin
            m_op    = mq.pop_front();
            m_start = 1;
            m_busy  = 1;
         end else begin
            m_start = 0;
            if (m_free) m_busy = 0;
         end
         if (m_acc) mq.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready",  in_ready,  32'(mq.size() < DEPTH));
         chk("level",     level,     32'(mq.size()));
         chk("start",     start,     m_start);
         chk("busy",      busy,      m_busy);
         chk("operand",   operand,   m_op);
         chk("jobs_done", jobs_done, m_cnt);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_start(output bit ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (start) begin
            ok = 1;
            return;
         end
         tick();
      end
      chk("start_timeout", start, 1);
   endtask

   task automatic serve(input int dly, input bit spur, input bit more, output logic [DATA_W-1:0] op);
      bit ok;
      wait_start(ok);
      op   = operand;
      done = spur;
      tick();
      done = 1'b0;
      repeat (dly) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      if (more) chk("b2b_start", start, 1);
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   logic [DATA_W-1:0] exp_q[$];

   initial begin
      logic [DATA_W-1:0] op;

      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", in_ready, 1);
      chk("rel_start", start, 0);
      chk("rel_busy", busy, 0);
      chk("rel_operand", operand, 0);
      chk("rel_level", level, 0);
      chk("rel_jobs", jobs_done, 0);

      // single job: start visible two cycles after the word is accepted
      push_word(16'h1234);
      chk("sj_level", level, 1);
      chk("sj_nostart", start, 0);
      tick();
      chk("sj_start", start, 1);
      chk("sj_operand", operand, 16'h1234);
      chk("sj_level0", level, 0);
      tick();
      chk("sj_start_pulse", start, 0);
      chk("sj_busy", busy, 1);
      repeat (3) tick();
      chk("sj_busy_hold", busy, 1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("sj_jobs", jobs_done, 1);
      chk("sj_idle", busy, 0);

      // fill with done withheld; sixth word is refused
      for (int i = 1; i <= 6; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(i);
         if (i == 6) chk("fill_in_ready", in_ready, 0);
         tick();
      end
      in_valid = 1'b0;
      chk("fill_level", level, 4);
      chk("fill_operand", operand, 1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("fill_op2", operand, 2);
      chk("fill_start2", start, 1);
      chk("fill_level3", level, 3);
      chk("fill_ready", in_ready, 1);
      for (int k = 2; k <= 5; k++) begin
         serve(2, 0, k < 5, op);
         chk("fill_order", op, k);
      end
      chk("fill_jobs", jobs_done, 6);

      // back-to-back with a simultaneous push and pop at level 2
      push_word(16'hA001);
      push_word(16'hA002);
      push_word(16'hA003);
      tick();
      chk("pp_pre_level", level, 2);
      done     = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hA004;
      tick();
      done     = 1'b0;
      in_valid = 1'b0;
      chk("pp_level", level, 2);
      chk("pp_start", start, 1);
      for (int k = 2; k <= 4; k++) begin
         serve(4, 0, k < 4, op);
         chk("b2b_order", op, 16'hA000 + 16'(k));
      end
      chk("b2b_jobs", jobs_done, 10);

      // spurious done while idle
      repeat (2) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("spur_jobs", jobs_done, 10);
      chk("spur_busy", busy, 0);

      // reset in the middle of a job
      push_word(16'hB001);
      push_word(16'hB002);
      push_word(16'hB003);
      tick();
      chk("mid_busy", busy, 1);
      chk("mid_level", level, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_operand", operand, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_jobs", jobs_done, 0);
      tick();
      rst_n = 1'b1;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("late_done_jobs", jobs_done, 0);
      chk("late_done_busy", busy, 0);

      // 257 random jobs: counter wrap and pointer wrap ordering
      fork
         begin
            for (int i = 0; i < 257; i++) begin
               logic [DATA_W-1:0] d;
               bit acc;
               d        = 16'($urandom);
               in_valid = 1'b1;
               in_data  = d;
               acc      = 0;
               for (int w = 0; w < 200 && !acc; w++) begin
                  acc = in_ready;
                  tick();
               end
               in_valid = 1'b0;
               if (acc) exp_q.push_back(d);
               else chk("push_timeout", in_ready, 1);
               repeat ($urandom_range(0, 2)) tick();
            end
         end
         begin
            for (int i = 0; i < 257; i++) begin
               logic [DATA_W-1:0] got;
               serve($urandom_range(0, 3), $urandom_range(0, 3) == 0, 0, got);
               if (exp_q.size() == 0) chk("wrap_underflow", got, ~got);
               else chk("wrap_order", got, exp_q.pop_front());
            end
         end
      join
      tick();
      chk("wrap_jobs", jobs_done, 1);
      chk("wrap_level", level, 0);
      chk("wrap_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/job_dispatcher.md
# job_dispatcher

Upstream feeder for the iterative controller/datapath pair. It accepts operand words on a valid/ready stream and buffers them in a small FIFO. It launches one job at a time by loading the operand register and pulsing `start` for one cycle, then holds off until the controller's `done` before launching the next job. It also counts completed jobs for status.

## Interface

Parameters:
- `DATA_W`, 16: operand width.
- `DEPTH`, 4: FIFO depth; must be a power of two and at least 2.
- `CNT_W`, derived as `$clog2(DEPTH)+1`: width of `level`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: upstream word valid.
- `in_ready`, output, 1: FIFO can accept a word; equals `!full` (combinational from `level`).
- `in_data`, input, DATA_W: upstream operand word.
- `start`, output, 1: one-cycle launch pulse to the controller. Registered.
- `operand`, output, DATA_W: operand presented to the datapath. Registered and held stable from launch until `done`.
- `done`, input, 1: controller completion, high for one cycle at the end of a job.
- `busy`, output, 1: a job is launched and not yet completed. Registered.
- `level`, output, CNT_W: current FIFO occupancy, 0..DEPTH.
- `jobs_done`, output, 8: count of completed jobs; wraps from 255 to 0.

## Operation

- FIFO:
  - Circular buffer with read pointer, write pointer and occupancy counter `level`.
  - Push when `in_valid && in_ready`. Pop only on launch.
  - Pointers wrap from DEPTH-1 to 0.
  - Push and pop in the same cycle leaves `level` unchanged. This is allowed at any occupancy except full.
  - When full, `in_ready=0` and no push occurs, even if a pop happens in that cycle. There is no full-bypass.
  - When empty, no pop occurs, and there is no push-to-launch bypass.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE:
    - If `level>0`: load `operand` from the FIFO head, pop, and go to LAUNCH.
    - Otherwise stay in IDLE.
  - LAUNCH:
    - `start=1` and `busy=1` for exactly this one cycle.
    - Always go to WAIT next.
  - WAIT:
    - `busy=1`, `start=0`, `operand` held.
    - On `done=1`: increment `jobs_done`. If `level>0`, load the next head and pop in the same edge, then go to LAUNCH. Otherwise go to IDLE.
- `done` received in IDLE or LAUNCH is ignored: no count and no state change.
- `operand` changes only on a pop edge and never while in WAIT without `done`.
- Reset (asynchronous, at any time including mid-job):
  - State returns to IDLE and the FIFO is emptied (pointers and `level` = 0).
  - `start=0`, `busy=0`, `operand=0`, `jobs_done=0`.
  - `in_ready=1` once reset takes effect.
  - After reset, any job in flight in the controller is abandoned. A later `done` arriving in IDLE is ignored.

## Timing

- Push at edge t into an empty FIFO while IDLE:
  - `level=1` after t.
  - Pop and launch at edge t+1.
  - `start` is high in the cycle after t+1.
  - Latency from accepting the word to `start` is 2 cycles.
- `start` is high in the cycle before the controller's sampling edge. The controller loads `operand` one cycle later, and `operand` is stable throughout.
- `done` high at edge d:
  - `jobs_done` increments at edge d.
  - Back-to-back case: if the FIFO is non-empty, `start` is high in the cycle after d. This matches the controller re-entering its idle state on the following cycle.
- `in_ready` reflects `level` after the last edge. A pop does not raise `in_ready` within the same cycle.
- `level` updates on the push/pop edge itself.

## Test plan

- Reset check: hold `rst_n=0`, then release → `in_ready=1`, `start=0`, `busy=0`, `operand=0`, `level=0`, `jobs_done=0`.
- Single job:
  - Push `0x1234` at edge t → `start` high for one cycle after t+1 and `operand=0x1234`.
  - `busy` stays 1 until `done`. After `done`: `jobs_done=1`, state IDLE, `busy=0`.
- Fill and back-pressure, with `done` withheld:
  - Push 6 words `0x0001`..`0x0006` → one word is launched, the FIFO fills to `level=4`, and `in_ready=0` with the 6th word refused.
  - Pulse `done` → `operand=0x0002` and `start` pulses the next cycle. `level=3`, `in_ready=1`.
  - Launch order must be `0x0001`→`0x0002`→…→`0x0005`.
- Back-to-back:
  - Queue 3 jobs and reply with `done` 5 cycles after each `start` → each `start` follows its `done` by exactly 1 cycle, and `jobs_done` ends at 3.
  - Simultaneous push and pop at `level=2` → `level` stays 2.
- Spurious and reset-mid-job:
  - `done` pulsed while IDLE → `jobs_done` unchanged.
  - Assert `rst_n=0` in WAIT with `level=2` → `level=0`, `busy=0`, `operand=0` immediately; a later `done` is ignored.
- Wrap: complete 257 jobs → `jobs_done=1`, and FIFO pointer wrap preserves data order.
